// File: rtl/branch_pkg.sv
// Shared branch op encoding and redirect FSM states.
package branch_pkg;

  localparam int BR_OP_W = 20;

  typedef enum logic [4:0] {
    BEQ     = 5'd0,
    BNE     = 5'd1,
    BGEZ    = 5'd2,
    BGTZ    = 5'd3,
    BLEZ    = 5'd4,
    BLTZ    = 5'd5,
    BGEZAL  = 5'd6,
    BLTZAL  = 5'd7,
    J       = 5'd8,
    JAL     = 5'd9,
    JR      = 5'd10,
    JALR    = 5'd11,
    BEQL    = 5'd12,
    BNEL    = 5'd13,
    BGEZL   = 5'd14,
    BGTZL   = 5'd15,
    BLEZL   = 5'd16,
    BLTZL   = 5'd17,
    BGEZALL = 5'd18,
    BLTZALL = 5'd19
  } br_op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    ACTIVE    = 2'd2
  } redir_state_e;

endpackage

// File: rtl/branch_redirect_unit_cond.sv
// Branch condition evaluation and target computation.
module branch_cond
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [BR_OP_W-1:0] op,
  input  logic [XLEN-1:0]    rs,
  input  logic [XLEN-1:0]    rt,
  input  logic [XLEN-1:0]    pc,
  input  logic [15:0]        imm,
  input  logic [25:0]        jidx,
  output logic               cond,
  output logic               likely,
  output logic [XLEN-1:0]    target
);

  logic eq, neg, zero;
  logic [XLEN-1:0] pc4, btgt, jtgt;
  logic [BR_OP_W-1:0] hit;

  assign eq   = rs == rt;
  assign neg  = rs[XLEN-1];
  assign zero = rs == '0;
  assign pc4  = pc + XLEN'(4);
  assign btgt = pc4 + {{(XLEN-18){imm[15]}}, imm, 2'b00};
  assign jtgt = {pc4[XLEN-1:28], jidx, 2'b00};

  always_comb begin
    hit          = '0;
    hit[BEQ]     = op[BEQ] & eq;
    hit[BNE]     = op[BNE] & ~eq;
    hit[BGEZ]    = op[BGEZ] & ~neg;
    hit[BGTZ]    = op[BGTZ] & ~neg & ~zero;
    hit[BLEZ]    = op[BLEZ] & (neg | zero);
    hit[BLTZ]    = op[BLTZ] & neg;
    hit[BGEZAL]  = op[BGEZAL] & ~neg;
    hit[BLTZAL]  = op[BLTZAL] & neg;
    hit[J]       = op[J];
    hit[JAL]     = op[JAL];
    hit[JR]      = op[JR];
    hit[JALR]    = op[JALR];
    hit[BEQL]    = op[BEQL] & eq;
    hit[BNEL]    = op[BNEL] & ~eq;
    hit[BGEZL]   = op[BGEZL] & ~neg;
    hit[BGTZL]   = op[BGTZL] & ~neg & ~zero;
    hit[BLEZL]   = op[BLEZL] & (neg | zero);
    hit[BLTZL]   = op[BLTZL] & neg;
    hit[BGEZALL] = op[BGEZALL] & ~neg;
    hit[BLTZALL] = op[BLTZALL] & neg;
  end

  assign cond   = |hit;
  assign likely = |op[BR_OP_W-1:BEQL];

  always_comb begin
    target = btgt;
    unique case (1'b1)
      op[J], op[JAL]:   target = jtgt;
      op[JR], op[JALR]: target = rs;
      default:          target = btgt;
    endcase
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Decode-stage branch resolver with registered redirect/nullify
// handshake toward fetch and branch performance counters.
module branch_redirect_unit
  import branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int HAS_LIKELY = 1,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ds_valid,
  input  logic               ds_stall,
  input  logic               ds_go,
  input  logic [BR_OP_W-1:0] br_op,
  input  logic [XLEN-1:0]    rs_value,
  input  logic [XLEN-1:0]    rt_value,
  input  logic [XLEN-1:0]    ds_pc,
  input  logic [15:0]        imm,
  input  logic [25:0]        jidx,
  input  logic               fs_slot_valid,
  input  logic               fs_ready,
  input  logic               flush,
  output logic               br_stall,
  output logic [XLEN-1:0]    link_addr,
  output logic               redir_valid,
  output logic [XLEN-1:0]    redir_target,
  output logic               nullify_slot,
  output logic [CNT_W-1:0]   br_cnt,
  output logic [CNT_W-1:0]   taken_cnt
);

  localparam logic [BR_OP_W-1:0] OP_MASK = (HAS_LIKELY != 0) ?
    {BR_OP_W{1'b1}} : {{(BR_OP_W-12){1'b0}}, 12'hFFF};

  redir_state_e state;
  logic kind;
  logic [BR_OP_W-1:0] op;
  logic any_op, cond, likely, take, kill, cnt_en;
  logic [XLEN-1:0] tgt;

  assign op = br_op & OP_MASK;
  assign any_op = |op;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .op     (op),
    .rs     (rs_value),
    .rt     (rt_value),
    .pc     (ds_pc),
    .imm    (imm),
    .jidx   (jidx),
    .cond   (cond),
    .likely (likely),
    .target (tgt)
  );

  assign take      = any_op & cond & ds_valid;
  assign kill      = likely & ~cond & ds_valid;
  assign link_addr = ds_pc + XLEN'(8);
  assign br_stall  = ds_valid & any_op & (ds_stall | (state != IDLE));
  assign cnt_en    = ds_go & ds_valid & any_op & ~flush;

  // kind: 0 = redirect to target, 1 = nullify the delay slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      kind         <= 1'b0;
      redir_valid  <= 1'b0;
      nullify_slot <= 1'b0;
      redir_target <= '0;
    end else if (flush) begin
      state        <= IDLE;
      redir_valid  <= 1'b0;
      nullify_slot <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ds_go && (take || kill)) begin
            kind         <= kill;
            redir_target <= tgt;
            if (fs_slot_valid) begin
              state        <= ACTIVE;
              redir_valid  <= ~kill;
              nullify_slot <= kill;
            end else begin
              state <= WAIT_SLOT;
            end
          end
        end
        WAIT_SLOT: begin
          if (fs_slot_valid) begin
            state        <= ACTIVE;
            redir_valid  <= ~kind;
            nullify_slot <= kind;
          end
        end
        ACTIVE: begin
          if (fs_ready) begin
            state        <= IDLE;
            redir_valid  <= 1'b0;
            nullify_slot <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (cnt_en) begin
      br_cnt <= br_cnt + CNT_W'(1);
      if (take) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed + random checks of branch_redirect_unit against a
// request-level reference model, across three parameter sets.
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        reset, ds_valid, ds_stall, ds_go;
  logic [19:0] br_op;
  logic [31:0] rs, rt, pc;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic        slot, rdy, flush;
  int          opi;

  logic        rv[3], ns[3], brs[3];
  logic [31:0] tgt[3], link[3];
  logic [31:0] bc0, tc0, bc1, tc1;
  logic [3:0]  bc2, tc2;

  bit              m_req[3], m_slot[3], m_kind[3];
  logic [31:0]     m_tgt[3];
  longint unsigned m_bc[3], m_tc[3];
  int              cw[3] = '{32, 32, 4};
  bit              hl[3] = '{1'b1, 1'b0, 1'b1};

  int total = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign br_op = (opi >= 0) ? (20'd1 << opi) : 20'd0;

  branch_redirect_unit u_main (
    .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_stall(ds_stall),
    .ds_go(ds_go), .br_op(br_op), .rs_value(rs), .rt_value(rt),
    .ds_pc(pc), .imm(imm), .jidx(jidx), .fs_slot_valid(slot),
    .fs_ready(rdy), .flush(flush), .br_stall(brs[0]),
    .link_addr(link[0]), .redir_valid(rv[0]), .redir_target(tgt[0]),
    .nullify_slot(ns[0]), .br_cnt(bc0), .taken_cnt(tc0)
  );

  branch_redirect_unit #(.HAS_LIKELY(0)) u_nl (
    .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_stall(ds_stall),
    .ds_go(ds_go), .br_op(br_op), .rs_value(rs), .rt_value(rt),
    .ds_pc(pc), .imm(imm), .jidx(jidx), .fs_slot_valid(slot),
    .fs_ready(rdy), .flush(flush), .br_stall(brs[1]),
    .link_addr(link[1]), .redir_valid(rv[1]), .redir_target(tgt[1]),
    .nullify_slot(ns[1]), .br_cnt(bc1), .taken_cnt(tc1)
  );

  branch_redirect_unit #(.CNT_W(4)) u_c4 (
    .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_stall(ds_stall),
    .ds_go(ds_go), .br_op(br_op), .rs_value(rs), .rt_value(rt),
    .ds_pc(pc), .imm(imm), .jidx(jidx), .fs_slot_valid(slot),
    .fs_ready(rdy), .flush(flush), .br_stall(brs[2]),
    .link_addr(link[2]), .redir_valid(rv[2]), .redir_target(tgt[2]),
    .nullify_slot(ns[2]), .br_cnt(bc2), .taken_cnt(tc2)
  );

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    total++;
    assert (o === e) passes++;
    else $error("FAIL %s got=%0h exp=%0h", tag, o, e);
  endtask

  // Spec-level evaluation of the instruction currently in decode
  task automatic eval(input bit hlk, output bit tk, output bit kl,
                      output logic [31:0] t, output bit anyop);
    int o;
    bit c;
    o = opi;
    if (o >= 12 && !hlk) o = -1;
    anyop = (o >= 0);
    case (o)
      0, 12:          c = (rs == rt);
      1, 13:          c = (rs != rt);
      2, 6, 14, 18:   c = ($signed(rs) >= 0);
      5, 7, 17, 19:   c = ($signed(rs) < 0);
      3, 15:          c = ($signed(rs) > 0);
      4, 16:          c = ($signed(rs) <= 0);
      8, 9, 10, 11:   c = 1'b1;
      default:        c = 1'b0;
    endcase
    if (o == 8 || o == 9)
      t = ((pc + 32'd4) & 32'hF000_0000) | (32'(jidx) * 4);
    else if (o == 10 || o == 11)
      t = rs;
    else
      t = pc + 32'd4 + 32'(32'($signed(imm)) * 4);
    tk = anyop && c && ds_valid;
    kl = (o >= 12) && !c && ds_valid;
  endtask

  function automatic longint unsigned msk(int w);
    return (64'h1 << w) - 1;
  endfunction

  task automatic model_edge();
    bit tk, kl, anyop;
    logic [31:0] t;
    for (int i = 0; i < 3; i++) begin
      eval(hl[i], tk, kl, t, anyop);
      if (reset) begin
        m_req[i] = 0; m_slot[i] = 0; m_kind[i] = 0;
        m_tgt[i] = '0; m_bc[i] = 0; m_tc[i] = 0;
      end else begin
        if (ds_go && ds_valid && anyop && !flush) begin
          m_bc[i] = (m_bc[i] + 1) & msk(cw[i]);
          if (tk) m_tc[i] = (m_tc[i] + 1) & msk(cw[i]);
        end
        if (flush) m_req[i] = 0;
        else if (!m_req[i]) begin
          if (ds_go && (tk || kl)) begin
            m_req[i] = 1; m_kind[i] = kl; m_tgt[i] = t; m_slot[i] = slot;
          end
        end else if (!m_slot[i]) begin
          if (slot) m_slot[i] = 1;
        end else if (rdy) m_req[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    bit tk, kl, anyop;
    logic [31:0] t;
    logic [63:0] bo, to;
    for (int i = 0; i < 3; i++) begin
      eval(hl[i], tk, kl, t, anyop);
      bo = (i == 0) ? 64'(bc0) : (i == 1) ? 64'(bc1) : 64'(bc2);
      to = (i == 0) ? 64'(tc0) : (i == 1) ? 64'(tc1) : 64'(tc2);
      chk($sformatf("rv%0d", i), 64'(rv[i]),
          64'(m_req[i] && m_slot[i] && !m_kind[i]));
      chk($sformatf("ns%0d", i), 64'(ns[i]),
          64'(m_req[i] && m_slot[i] && m_kind[i]));
      chk($sformatf("tgt%0d", i), 64'(tgt[i]), 64'(m_tgt[i]));
      chk($sformatf("stall%0d", i), 64'(brs[i]),
          64'(ds_valid && anyop && (ds_stall || m_req[i])));
      chk($sformatf("link%0d", i), 64'(link[i]), 64'(pc + 32'd8));
      chk($sformatf("brcnt%0d", i), bo, 64'(m_bc[i]));
      chk($sformatf("tkcnt%0d", i), to, 64'(m_tc[i]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr();
    reset = 0; ds_valid = 0; ds_stall = 0; ds_go = 0; opi = -1;
    rs = 0; rt = 0; pc = 0; imm = 0; jidx = 0;
    slot = 0; rdy = 0; flush = 0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    clr();
    reset = 1;
    repeat (2) @(posedge clk);
    model_edge();
    #1;
    reset = 0;
    step();

    // beq taken, slot present
    opi = 0; rs = 5; rt = 5; pc = 32'h1000; imm = 16'h0004;
    slot = 1; rdy = 1; ds_valid = 1; ds_go = 1;
    step();
    chk("beq_rv", 64'(rv[0]), 64'd1);
    chk("beq_tgt", 64'(tgt[0]), 64'h1014);
    chk("beq_tk", 64'(tc0), 64'd1);
    clr(); rdy = 1;
    step();
    chk("beq_drop", 64'(rv[0]), 64'd0);

    // bnel not taken: nullify, ignored without likely support
    do_reset();
    opi = 13; rs = 7; rt = 7; pc = 32'h2000;
    slot = 1; ds_valid = 1; ds_go = 1;
    step();
    chk("bnel_ns", 64'(ns[0]), 64'd1);
    chk("bnel_rv", 64'(rv[0]), 64'd0);
    chk("bnel_br", 64'(bc0), 64'd1);
    chk("bnel_tk", 64'(tc0), 64'd0);
    chk("bnel_nl_ns", 64'(ns[1]), 64'd0);
    chk("bnel_nl_rv", 64'(rv[1]), 64'd0);
    clr(); rdy = 1;
    step();

    // jal with delayed slot, then held by fs_ready low
    do_reset();
    opi = 9; pc = 32'h8FFF_FFFC; jidx = 26'h3FF_FFFF;
    ds_valid = 1; ds_go = 1; slot = 0;
    #1;
    chk("jal_link", 64'(link[0]), 64'h9000_0004);
    step();
    clr();
    repeat (2) begin
      step();
      chk("jal_wait", 64'(rv[0]), 64'd0);
    end
    slot = 1;
    step();
    chk("jal_rv", 64'(rv[0]), 64'd1);
    chk("jal_tgt", 64'(tgt[0]), 64'h9FFF_FFFC);
    slot = 0; opi = 0; ds_valid = 1; rdy = 0;
    repeat (4) begin
      step();
      chk("hold_rv", 64'(rv[0]), 64'd1);
      chk("hold_tgt", 64'(tgt[0]), 64'h9FFF_FFFC);
      chk("hold_stall", 64'(brs[0]), 64'd1);
    end
    clr(); rdy = 1;
    step();
    chk("hold_drop", 64'(rv[0]), 64'd0);

    // flush with ds_go, then flush during ACTIVE
    do_reset();
    opi = 10; rs = 32'h1234; ds_valid = 1; ds_go = 1; slot = 1; flush = 1;
    step();
    chk("flush_go", 64'(rv[0]), 64'd0);
    chk("flush_cnt", 64'(bc0), 64'd0);
    flush = 0;
    step();
    chk("jr_rv", 64'(rv[0]), 64'd1);
    chk("jr_tgt", 64'(tgt[0]), 64'h1234);
    clr(); flush = 1;
    step();
    chk("flush_act", 64'(rv[0]), 64'd0);
    clr();
    opi = 0; ds_valid = 1;
    step();
    chk("flush_idle", 64'(brs[0]), 64'd0);

    // counter wrap at 4 bits, negative offset wrap
    do_reset();
    opi = 1; rs = 3; rt = 3; ds_valid = 1; ds_go = 1;
    repeat (16) step();
    chk("wrap_c4", 64'(bc2), 64'd0);
    chk("wrap_c32", 64'(bc0), 64'd16);
    clr();
    opi = 0; pc = 32'h10; imm = 16'h8000; ds_valid = 1; ds_go = 1; slot = 1;
    step();
    chk("neg_tgt", 64'(tgt[0]), 64'hFFFE_0014);
    clr(); rdy = 1;
    step();

    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      reset    = ($urandom % 60) == 0;
      flush    = ($urandom % 20) == 0;
      ds_valid = ($urandom % 4) != 0;
      ds_stall = ($urandom % 5) == 0;
      ds_go    = ds_stall ? 1'b0 : 1'($urandom % 2);
      opi      = int'($urandom % 22) - 2;
      rt       = $urandom;
      case ($urandom % 4)
        0: rs = 0;
        1: rs = rt;
        2: rs = $urandom | 32'h8000_0000;
        default: rs = $urandom;
      endcase
      pc   = $urandom & 32'hFFFF_FFFC;
      imm  = 16'($urandom);
      jidx = 26'($urandom);
      slot = 1'($urandom % 2);
      rdy  = ($urandom % 3) == 0;
      step();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
